// File: rtl/iob_soc_sut_rst_seq_pkg.sv
// Shared definitions for the SUT reset/bring-up sequencer: 3-bit state codes
// (also used for software status decode) and a counter sizing helper.
package iob_soc_sut_rst_seq_pkg;

  localparam logic [2:0] S_HOLD      = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_WAIT_CAL  = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_RETRY     = 3'd4;
  localparam logic [2:0] S_FAIL      = 3'd5;

  typedef enum logic [2:0] {
    ST_HOLD      = S_HOLD,
    ST_WAIT_LOCK = S_WAIT_LOCK,
    ST_WAIT_CAL  = S_WAIT_CAL,
    ST_RUN       = S_RUN,
    ST_RETRY     = S_RETRY,
    ST_FAIL      = S_FAIL
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/iob_sync.sv
// Two-flop synchroniser for asynchronous level inputs; cleared to 0 by the
// asynchronous reset.
module iob_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/iob_soc_sut_rst_seq.sv
// Reset/bring-up sequencer: holds DDR3 in reset, waits for stable PLL lock and
// calibration with bounded retries, then releases the SUT core reset.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// HOLD      | DDR controller held in reset for RST_HOLD cycles
// WAIT_LOCK | DDR released, waiting for LOCK_STABLE consecutive lock cycles
// WAIT_CAL  | waiting for init_done & cal_success, bounded by CAL_TIMEOUT
// RUN       | memory usable, SUT core out of reset
// RETRY     | one-cycle bookkeeping of a failed attempt
// FAIL      | retries exhausted; terminal until arst_n_i
module iob_soc_sut_rst_seq
  import iob_soc_sut_rst_seq_pkg::*;
#(
  parameter int RST_HOLD    = 16,
  parameter int LOCK_STABLE = 1024,
  parameter int CAL_TIMEOUT = 1 << 20,
  parameter int MAX_RETRIES = 3
) (
  input  logic       clk_i,
  input  logic       arst_n_i,
  input  logic       pll_locked_i,
  input  logic       init_done_i,
  input  logic       cal_success_i,
  input  logic       cal_fail_i,
  output logic       ddr_rst_n_o,
  output logic       sys_rst_o,
  output logic       fail_o,
  output logic [2:0] state_o,
  output logic [1:0] retries_o
);

  localparam int CW = $clog2(max3(RST_HOLD, LOCK_STABLE, CAL_TIMEOUT)) + 1;
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(RST_HOLD - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] CAL_LAST    = CW'(CAL_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [1:0]    RETRY_LIMIT = 2'(MAX_RETRIES);

  logic [3:0]    status_raw;
  logic [3:0]    status_s;
  logic          lock_s, done_s, ok_s, fail_s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    retries_q, retries_d;
  logic          ddr_rst_n_d, sys_rst_d, fail_d;

  assign status_raw = {cal_fail_i, cal_success_i, init_done_i, pll_locked_i};

  iob_sync #(.WIDTH(4)) u_sync (
    .clk    (clk_i),
    .arst_n (arst_n_i),
    .d      (status_raw),
    .q      (status_s)
  );

  assign {fail_s, ok_s, done_s, lock_s} = status_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_HOLD: begin
        if (cnt_q == '0) state_d = ST_WAIT_LOCK;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      ST_WAIT_LOCK: begin
        if (!lock_s)                 cnt_d   = '0;
        else if (cnt_q == LOCK_LAST) state_d = ST_WAIT_CAL;
        else                         cnt_d   = cnt_q + CNT_ONE;
      end
      ST_WAIT_CAL: begin
        // cal_fail outranks success, which outranks lock loss and timeout
        if (fail_s)                 state_d = ST_RETRY;
        else if (done_s && ok_s)    state_d = ST_RUN;
        else if (!lock_s)           state_d = ST_HOLD;
        else if (cnt_q == CAL_LAST) state_d = ST_RETRY;
        else                        cnt_d   = cnt_q + CNT_ONE;
      end
      ST_RUN: begin
        if (!lock_s || !done_s) state_d = ST_HOLD;
      end
      ST_RETRY: begin
        state_d = (retries_q == RETRY_LIMIT) ? ST_FAIL : ST_HOLD;
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_HOLD;
      end
    endcase

    // the single counter is reloaded on every state entry
    if (state_d != state_q) cnt_d = (state_d == ST_HOLD) ? HOLD_LOAD : '0;

    retries_d = retries_q;
    if (state_d == ST_RETRY && state_q != ST_RETRY && retries_q != RETRY_LIMIT)
      retries_d = retries_q + 2'd1;

    ddr_rst_n_d = state_d inside {ST_WAIT_LOCK, ST_WAIT_CAL, ST_RUN};
    sys_rst_d   = (state_d != ST_RUN);
    fail_d      = fail_o || (state_d == ST_FAIL);
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= ST_HOLD;
      cnt_q       <= HOLD_LOAD;
      retries_q   <= '0;
      ddr_rst_n_o <= 1'b0;
      sys_rst_o   <= 1'b1;
      fail_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      ddr_rst_n_o <= ddr_rst_n_d;
      sys_rst_o   <= sys_rst_d;
      fail_o      <= fail_d;
    end
  end

  assign state_o   = state_q;
  assign retries_o = retries_q;

endmodule

// File: tb/tb_iob_soc_sut_rst_seq.sv
// Self-checking bench for iob_soc_sut_rst_seq against an elapsed-time model.
module tb_iob_soc_sut_rst_seq;
  import iob_soc_sut_rst_seq_pkg::*;

  localparam int RH = 4;
  localparam int LS = 8;
  localparam int CT = 100;
  localparam int MR = 2;
  localparam logic [7:0] RESET_VEC = 8'b0100_0000;

  logic       clk_i = 1'b0;
  logic       arst_n_i = 1'b1;
  logic       pll_locked_i = 1'b0;
  logic       init_done_i = 1'b0;
  logic       cal_success_i = 1'b0;
  logic       cal_fail_i = 1'b0;
  logic       ddr_rst_n_o, sys_rst_o, fail_o;
  logic [2:0] state_o;
  logic [1:0] retries_o;
  logic [7:0] obs;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model: phase, time spent in phase, lock run length, delayed inputs
  logic [2:0] m_phase;
  int         m_time, m_run, m_retries;
  logic [3:0] m_s1, m_s2;

  always #5 clk_i = ~clk_i;

  iob_soc_sut_rst_seq #(
    .RST_HOLD(RH), .LOCK_STABLE(LS), .CAL_TIMEOUT(CT), .MAX_RETRIES(MR)
  ) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .pll_locked_i(pll_locked_i),
    .init_done_i(init_done_i), .cal_success_i(cal_success_i), .cal_fail_i(cal_fail_i),
    .ddr_rst_n_o(ddr_rst_n_o), .sys_rst_o(sys_rst_o), .fail_o(fail_o),
    .state_o(state_o), .retries_o(retries_o)
  );

  assign obs = {ddr_rst_n_o, sys_rst_o, fail_o, state_o, retries_o};

  function automatic void m_reset();
    m_phase = S_HOLD; m_time = 0; m_run = 0; m_retries = 0;
    m_s1 = '0; m_s2 = '0;
  endfunction

  function automatic void m_enter(input logic [2:0] p);
    m_phase = p; m_time = 0; m_run = 0;
    if (p == S_RETRY) m_retries++;
  endfunction

  function automatic void m_edge();
    logic lk, dn, ok, fl;
    {fl, ok, dn, lk} = m_s2;
    case (m_phase)
      S_HOLD: begin
        m_time++;
        if (m_time == RH) m_enter(S_WAIT_LOCK);
      end
      S_WAIT_LOCK: begin
        if (lk) begin
          m_run++;
          if (m_run == LS) m_enter(S_WAIT_CAL);
        end else m_run = 0;
      end
      S_WAIT_CAL: begin
        m_time++;
        if (fl)             m_enter(S_RETRY);
        else if (dn && ok)  m_enter(S_RUN);
        else if (!lk)       m_enter(S_HOLD);
        else if (m_time == CT) m_enter(S_RETRY);
      end
      S_RUN:   if (!lk || !dn) m_enter(S_HOLD);
      S_RETRY: m_enter((m_retries == MR) ? S_FAIL : S_HOLD);
      default: ;
    endcase
    m_s2 = m_s1;
    m_s1 = {cal_fail_i, cal_success_i, init_done_i, pll_locked_i};
  endfunction

  function automatic logic [7:0] m_exp();
    logic ddr, sys, fl;
    ddr = (m_phase == S_WAIT_LOCK) || (m_phase == S_WAIT_CAL) || (m_phase == S_RUN);
    sys = (m_phase != S_RUN);
    fl  = (m_phase == S_FAIL);
    return {ddr, sys, fl, m_phase, 2'(m_retries)};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    m_edge();
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic apply_reset(input logic lk, input logic dn, input logic ok, input logic fl);
    @(negedge clk_i);
    arst_n_i = 1'b0;
    pll_locked_i = lk; init_done_i = dn; cal_success_i = ok; cal_fail_i = fl;
    m_reset();
    repeat (2) @(negedge clk_i);
    arst_n_i = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    #2 arst_n_i = 1'b0;
    #1;
    checks++;
    if (obs !== RESET_VEC) begin
      failures++; $display("FAIL reset_async got=%b exp=%b", obs, RESET_VEC);
    end
    repeat (3) @(negedge clk_i);
    checks++;
    if (obs !== RESET_VEC) begin
      failures++; $display("FAIL reset_held got=%b exp=%b", obs, RESET_VEC);
    end
  endtask

  task automatic test_nominal();
    int ddr_rise, sys_fall;
    apply_reset(1'b1, 1'b1, 1'b1, 1'b0);
    ddr_rise = -1; sys_fall = -1;
    repeat (20) begin
      tick();
      checks++;
      if (obs !== m_exp()) begin
        failures++; $display("FAIL nominal_cycle cyc=%0d got=%b exp=%b", cyc, obs, m_exp());
      end
      if (ddr_rise < 0 && ddr_rst_n_o === 1'b1) ddr_rise = cyc;
      if (sys_fall < 0 && sys_rst_o === 1'b0) sys_fall = cyc;
    end
    checks++;
    if (ddr_rise != RH) begin
      failures++; $display("FAIL nominal_ddr_rise got=%0d exp=%0d", ddr_rise, RH);
    end
    checks++;
    if (sys_fall != RH + LS + 1) begin
      failures++; $display("FAIL nominal_sys_fall got=%0d exp=%0d", sys_fall, RH + LS + 1);
    end
    checks++;
    if (retries_o !== 2'd0) begin
      failures++; $display("FAIL nominal_retries got=%0d exp=0", retries_o);
    end
  endtask

  task automatic test_lock_glitch();
    int d, run_at;
    d = $urandom_range(5, 8);
    apply_reset(1'b1, 1'b1, 1'b1, 1'b0);
    run_at = -1;
    repeat (d) begin
      tick();
      checks++;
      if (obs !== m_exp()) begin
        failures++; $display("FAIL glitch_cycle cyc=%0d got=%b exp=%b", cyc, obs, m_exp());
      end
    end
    pll_locked_i = 1'b0;
    tick();
    pll_locked_i = 1'b1;
    repeat (30) begin
      tick();
      checks++;
      if (obs !== m_exp()) begin
        failures++; $display("FAIL glitch_cycle cyc=%0d got=%b exp=%b", cyc, obs, m_exp());
      end
      if (run_at < 0 && state_o === S_RUN) run_at = cyc;
    end
    checks++;
    if (run_at != d + 12) begin
      failures++; $display("FAIL glitch_run_cycle got=%0d exp=%0d", run_at, d + 12);
    end
  endtask

  task automatic test_cal_fail_retry();
    bit reached, seen_retry;
    reached = 0; seen_retry = 0;
    apply_reset(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40 && !reached; i++) begin
      tick();
      checks++;
      if (obs !== m_exp()) begin
        failures++; $display("FAIL calfail_cycle cyc=%0d got=%b exp=%b", cyc, obs, m_exp());
      end
      if (state_o === S_WAIT_CAL) reached = 1;
    end
    checks++;
    if (!reached) begin
      failures++; $display("FAIL calfail_wait_cal got=%0d exp=%0d", state_o, S_WAIT_CAL);
    end
    repeat ($urandom_range(0, 10)) tick();
    cal_fail_i = 1'b1;
    tick();
    cal_fail_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs !== m_exp()) begin
        failures++; $display("FAIL calfail_cycle cyc=%0d got=%b exp=%b", cyc, obs, m_exp());
      end
      if (state_o === S_RETRY && retries_o === 2'd1) seen_retry = 1;
    end
    checks++;
    if (!seen_retry) begin
      failures++; $display("FAIL calfail_retry_seen got=0 exp=1");
    end
    cal_success_i = 1'b1;
    reached = 0;
    for (int i = 0; i < 40 && !reached; i++) begin
      tick();
      checks++;
      if (obs !== m_exp()) begin
        failures++; $display("FAIL calfail_cycle cyc=%0d got=%b exp=%b", cyc, obs, m_exp());
      end
      if (state_o === S_RUN) reached = 1;
    end
    checks++;
    if (!reached || retries_o !== 2'd1 || fail_o !== 1'b0) begin
      failures++;
      $display("FAIL calfail_second_attempt got state=%0d retries=%0d fail=%b exp state=3 retries=1 fail=0",
               state_o, retries_o, fail_o);
    end
  endtask

  task automatic test_double_timeout();
    int fail_at;
    fail_at = -1;
    apply_reset(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (240) begin
      tick();
      checks++;
      if (obs !== m_exp()) begin
        failures++; $display("FAIL timeout_cycle cyc=%0d got=%b exp=%b", cyc, obs, m_exp());
      end
      if (fail_at < 0 && state_o === S_FAIL) fail_at = cyc;
    end
    checks++;
    if (fail_at != 226) begin
      failures++; $display("FAIL timeout_fail_cycle got=%0d exp=226", fail_at);
    end
    checks++;
    if (obs !== 8'b0_1_1_101_10) begin
      failures++; $display("FAIL timeout_final got=%b exp=%b", obs, 8'b0_1_1_101_10);
    end
    repeat (40) begin
      pll_locked_i = 1'($urandom_range(0, 1));
      init_done_i = 1'($urandom_range(0, 1));
      cal_success_i = 1'($urandom_range(0, 1));
      cal_fail_i = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (obs !== 8'b0_1_1_101_10) begin
        failures++; $display("FAIL fail_sticky cyc=%0d got=%b exp=%b", cyc, obs, 8'b0_1_1_101_10);
      end
    end
  endtask

  task automatic test_simultaneous_and_loss();
    bit reached, seen_retry;
    int c, hold_at;
    reached = 0; seen_retry = 0; hold_at = -1;
    apply_reset(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40 && !reached; i++) begin
      tick();
      if (state_o === S_WAIT_CAL) reached = 1;
    end
    cal_fail_i = 1'b1; cal_success_i = 1'b1;
    tick();
    cal_fail_i = 1'b0; cal_success_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (obs !== m_exp()) begin
        failures++; $display("FAIL simul_cycle cyc=%0d got=%b exp=%b", cyc, obs, m_exp());
      end
      if (state_o === S_RETRY) seen_retry = 1;
    end
    checks++;
    if (!seen_retry) begin
      failures++; $display("FAIL simul_retry_seen got=0 exp=1");
    end
    cal_success_i = 1'b1;
    reached = 0;
    for (int i = 0; i < 40 && !reached; i++) begin
      tick();
      checks++;
      if (obs !== m_exp()) begin
        failures++; $display("FAIL simul_cycle cyc=%0d got=%b exp=%b", cyc, obs, m_exp());
      end
      if (state_o === S_RUN) reached = 1;
    end
    repeat ($urandom_range(1, 10)) tick();
    init_done_i = 1'b0;
    c = cyc;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (obs !== m_exp()) begin
        failures++; $display("FAIL loss_cycle cyc=%0d got=%b exp=%b", cyc, obs, m_exp());
      end
      if (hold_at < 0 && state_o === S_HOLD && sys_rst_o === 1'b1) hold_at = cyc;
    end
    checks++;
    if (hold_at != c + 3 || retries_o !== 2'd1) begin
      failures++;
      $display("FAIL loss_to_hold got cycle=%0d retries=%0d exp cycle=%0d retries=1", hold_at, retries_o, c + 3);
    end
    init_done_i = 1'b1;
    repeat (25) begin
      tick();
      checks++;
      if (obs !== m_exp()) begin
        failures++; $display("FAIL loss_recover cyc=%0d got=%b exp=%b", cyc, obs, m_exp());
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (12 + $urandom_range(1, 30)) begin
      tick();
      checks++;
      if (obs !== m_exp()) begin
        failures++; $display("FAIL midrst_cycle cyc=%0d got=%b exp=%b", cyc, obs, m_exp());
      end
    end
    checks++;
    if (state_o !== S_WAIT_CAL) begin
      failures++; $display("FAIL midrst_in_wait_cal got=%0d exp=%0d", state_o, S_WAIT_CAL);
    end
    #2 arst_n_i = 1'b0;
    #1;
    checks++;
    if (obs !== RESET_VEC) begin
      failures++; $display("FAIL midrst_wait_cal got=%b exp=%b", obs, RESET_VEC);
    end
    apply_reset(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (230) tick();
    checks++;
    if (obs !== m_exp() || state_o !== S_FAIL) begin
      failures++; $display("FAIL midrst_reach_fail got=%b exp=%b", obs, m_exp());
    end
    #2 arst_n_i = 1'b0;
    #1;
    checks++;
    if (obs !== RESET_VEC) begin
      failures++; $display("FAIL midrst_fail got=%b exp=%b", obs, RESET_VEC);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      apply_reset(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
      repeat (300) begin
        pll_locked_i = ($urandom_range(0, 31) != 0);
        init_done_i = ($urandom_range(0, 31) != 0);
        cal_success_i = ($urandom_range(0, 3) == 0);
        cal_fail_i = ($urandom_range(0, 59) == 0);
        tick();
        checks++;
        if (obs !== m_exp()) begin
          failures++; $display("FAIL random_cycle round=%0d cyc=%0d got=%b exp=%b", r, cyc, obs, m_exp());
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    test_reset();
    test_nominal();
    test_lock_glitch();
    test_cal_fail_retry();
    test_double_timeout();
    test_simultaneous_and_loss();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
